// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one bit of b per cycle, WIDTH cycles.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic               active_q, active_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    // product already includes the bit being processed this cycle,
    // so on the done cycle it is the complete result
    always_comb begin
        product = acc_q + (mplier_q[0] ? mcand_q : '0);
        done    = active_q && (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            acc_d    = '0;
            mplier_d = b;
        end else if (active_q) begin
            acc_d    = product;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready handshake, single-cycle AND/XOR/ADD,
// multi-cycle MUL through alu_mul_seq. One operation in flight.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               zero,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [2*WIDTH-1:0] alu_value;
    logic [2*WIDTH-1:0] mul_product;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    op_e                op_in;

    assign op_in = op_e'(op);

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (op_in == OP_MUL) ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_value = '0;
        unique case (op_in)
            OP_AND:  alu_value = {{WIDTH{1'b0}}, a & b};
            OP_XOR:  alu_value = {{WIDTH{1'b0}}, a ^ b};
            OP_ADD:  alu_value = {{(WIDTH-1){1'b0}}, {1'b0, a} + {1'b0, b}};
            default: alu_value = '0;
        endcase
    end

    // operands are only sampled on the accepting edge; the result
    // register then holds until the next accepted operation
    always_comb begin
        accept    = (state_q == IDLE) && in_valid;
        mul_start = accept && (op_in == OP_MUL);
        result_d  = result_q;
        if (accept && (op_in != OP_MUL)) begin
            result_d = alu_value;
        end else if ((state_q == MUL) && mul_done) begin
            result_d = mul_product;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = result_q;
        zero      = (state_q == DONE) && (result_q == '0);
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corners plus random ops,
// on a WIDTH=8 instance and a WIDTH=2 instance.
module tb_alu_seq;

    localparam int W = 8;

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [1:0]  op = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic        zero;
    logic        busy;

    logic        in_valid2 = 1'b0;
    logic [1:0]  a2 = '0;
    logic [1:0]  b2 = '0;
    logic [1:0]  op2 = '0;
    logic        out_ready2 = 1'b1;
    logic        in_ready2;
    logic        out_valid2;
    logic [3:0]  result2;
    logic        zero2;
    logic        busy2;

    exp_t q8[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   first8 = 1'b1;
    int   rdy_mode = 2;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .busy     (busy)
    );

    alu_seq #(.WIDTH(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid2),
        .in_ready (in_ready2),
        .a        (a2),
        .b        (b2),
        .op       (op2),
        .out_valid(out_valid2),
        .out_ready(out_ready2),
        .result   (result2),
        .zero     (zero2),
        .busy     (busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp_v, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)",
                 name, cyc);
    endtask

    function automatic int model(input int o, input int x, input int y);
        case (o)
            0:       return x & y;
            1:       return x ^ y;
            2:       return x + y;
            default: return x * y;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q8.size() == 0) begin
                fail("unexpected_out8");
            end else begin
                if (first8) begin
                    chk("latency8", cyc - q8[0].acc + 1, q8[0].lat);
                    first8 = 1'b0;
                end
                chk("result8", result, q8[0].res);
                chk("zero8", zero, q8[0].res == 0);
                if (out_ready) begin
                    void'(q8.pop_front());
                    first8 = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2) begin
            if (q2.size() == 0) begin
                fail("unexpected_out2");
            end else begin
                chk("latency2", cyc - q2[0].acc + 1, q2[0].lat);
                chk("result2", result2, q2[0].res);
                chk("zero2", zero2, q2[0].res == 0);
                void'(q2.pop_front());
            end
        end
    end

    // called at #1 after a rising edge; pulses junk while busy
    task automatic issue8(input int o, input int x, input int y);
        int t = 0;
        while (in_ready !== 1'b1 && t < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            op = 2'($urandom);
            @(posedge clk); #1;
            t++;
        end
        if (in_ready !== 1'b1) begin
            in_valid = 1'b0;
            fail("accept_timeout8");
            return;
        end
        in_valid = 1'b1;
        op = 2'(o);
        a = 8'(x);
        b = 8'(y);
        @(posedge clk); #1;
        q8.push_back('{res: 16'(model(o, x, y)),
                       lat: (o == 3) ? W + 1 : 1, acc: cyc});
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 2'($urandom);
    endtask

    task automatic issue2(input int o, input int x, input int y);
        int t = 0;
        while (in_ready2 !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (in_ready2 !== 1'b1) begin
            fail("accept_timeout2");
            return;
        end
        in_valid2 = 1'b1;
        op2 = 2'(o);
        a2 = 2'(x);
        b2 = 2'(y);
        @(posedge clk); #1;
        q2.push_back('{res: 16'(model(o, x, y)),
                       lat: (o == 3) ? 3 : 1, acc: cyc});
        in_valid2 = 1'b0;
        a2 = 2'($urandom);
        b2 = 2'($urandom);
    endtask

    task automatic drain8();
        int t = 0;
        while (q8.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (q8.size() != 0) fail("drain8");
    endtask

    initial begin
        int t;
        int o;
        int x;
        int y;

        // an operation offered during reset must be dropped
        in_valid = 1'b1;
        op = 2'd2;
        a = 8'd3;
        b = 8'd4;
        in_valid2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_in_ready2", in_ready2, 1);
        chk("rst_out_valid2", out_valid2, 0);

        for (int i = 0; i < 4; i++) issue2(i, 2, 3);

        issue8(3, 255, 255);
        issue8(2, 255, 255);
        issue8(0, 8'h0F, 8'hF0);
        issue8(1, 8'h0F, 8'hF0);
        issue8(3, 0, 173);
        issue8(3, 255, 0);
        drain8();

        // backpressure with ignored in_valid pulses while held
        rdy_mode = 1;
        issue8(3, 12, 10);
        t = 0;
        while (out_valid !== 1'b1 && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        if (out_valid !== 1'b1) fail("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result", result, 120);
            in_valid = 1'b1;
            a = 8'd1;
            b = 8'd1;
            op = 2'd2;
            @(posedge clk); #1;
        end
        rdy_mode = 2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_busy", busy, 0);
        chk("bp_release_out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("bp_no_accept", in_ready, 1);

        // reset in the third multiply cycle
        issue8(3, 200, 77);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q8.delete();
        first8 = 1'b1;
        chk("midmul_in_ready", in_ready, 1);
        chk("midmul_out_valid", out_valid, 0);
        chk("midmul_result", result, 0);
        chk("midmul_busy", busy, 0);
        issue8(2, 1, 1);
        drain8();

        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            o = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0:       x = 0;
                1:       x = 255;
                default: x = $urandom_range(0, 255);
            endcase
            case ($urandom_range(0, 5))
                0:       y = 0;
                1:       y = 255;
                default: y = $urandom_range(0, 255);
            endcase
            issue8(o, x, y);
        end
        drain8();
        rdy_mode = 2;
        repeat (20) @(posedge clk);
        #1;
        if (q2.size() != 0) fail("drain2");
        chk("end_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
